// File: rtl/keccak_round_sequencer.sv
// Round sequencer for the low-throughput Keccak-f[1600] core: walks a one-hot
// round index once per unstalled cycle and holds done until the consumer acks.
module keccak_round_sequencer #(
  parameter int ROUNDS = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              ack,
  output logic              ready,
  output logic [ROUNDS-1:0] round,
  output logic [4:0]        round_num,
  output logic              first,
  output logic              last,
  output logic              done,
  output logic [15:0]       perm_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } stateT;

  stateT             state;
  stateT             stateNext;
  logic [ROUNDS-1:0] roundReg;
  logic [ROUNDS-1:0] roundNext;
  logic [4:0]        roundNumReg;
  logic [4:0]        roundNumNext;
  logic [15:0]       permCountReg;
  logic [15:0]       permCountNext;

  // State and round bookkeeping registers; reset abandons any in-flight permutation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      roundReg     <= '0;
      roundNumReg  <= '0;
      permCountReg <= '0;
    end else begin
      state        <= stateNext;
      roundReg     <= roundNext;
      roundNumReg  <= roundNumNext;
      permCountReg <= permCountNext;
    end
  end

  // Next-state and next-round logic; the count only moves on the final round.
  always_comb begin
    stateNext     = state;
    roundNext     = roundReg;
    roundNumNext  = roundNumReg;
    permCountNext = permCountReg;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext    = RUN;
          roundNext    = ROUNDS'(1);
          roundNumNext = '0;
        end
      end
      RUN: begin
        if (!stall) begin
          if (roundReg[ROUNDS-1]) begin
            stateNext     = DONE;
            roundNext     = '0;
            roundNumNext  = '0;
            permCountNext = permCountReg + 16'd1;
          end else begin
            roundNext    = roundReg << 1;
            roundNumNext = roundNumReg + 5'd1;
          end
        end
      end
      DONE: begin
        if (ack) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Outputs come purely from registered state, so none depends on an input.
  always_comb begin
    ready      = (state == IDLE);
    done       = (state == DONE);
    round      = roundReg;
    round_num  = roundNumReg;
    first      = roundReg[0];
    last       = roundReg[ROUNDS-1];
    perm_count = permCountReg;
  end

endmodule

// File: tb/tb_keccak_round_sequencer.sv
// Testbench for keccak_round_sequencer: directed scenarios plus random traffic,
// all compared against a cycle-level phase/round-index model.
module tb_keccak_round_sequencer;

  localparam int ROUNDS = 24;

  logic              clk;
  logic              reset;
  logic              start;
  logic              stall;
  logic              ack;
  logic              ready;
  logic [ROUNDS-1:0] round;
  logic [4:0]        round_num;
  logic              first;
  logic              last;
  logic              done;
  logic [15:0]       perm_count;

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0 = idle, 1 = running round idx, 2 = finished.
  int          modelPhase;
  int          modelIdx;
  int unsigned modelPerms;

  keccak_round_sequencer #(.ROUNDS(ROUNDS)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stall      (stall),
    .ack        (ack),
    .ready      (ready),
    .round      (round),
    .round_num  (round_num),
    .first      (first),
    .last       (last),
    .done       (done),
    .perm_count (perm_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    modelPhase = 0;
    modelIdx   = 0;
    modelPerms = 0;
  endtask

  task automatic modelStep(input logic s, input logic st, input logic a);
    case (modelPhase)
      0: if (s) begin
        modelPhase = 1;
        modelIdx   = 0;
      end
      1: if (!st) begin
        if (modelIdx == ROUNDS - 1) begin
          modelPhase = 2;
          modelPerms = (modelPerms + 1) % 65536;
        end else begin
          modelIdx = modelIdx + 1;
        end
      end
      default: if (a) modelPhase = 0;
    endcase
  endtask

  task automatic compareAll();
    logic [31:0] expRound;
    expRound = (modelPhase == 1) ? (32'd1 << modelIdx) : 32'd0;
    checkOutput("round", round, expRound);
    checkOutput("roundNum", round_num, (modelPhase == 1) ? modelIdx : 0);
    checkOutput("ready", ready, modelPhase == 0);
    checkOutput("done", done, modelPhase == 2);
    checkOutput("first", first, (modelPhase == 1) && (modelIdx == 0));
    checkOutput("last", last, (modelPhase == 1) && (modelIdx == ROUNDS - 1));
    checkOutput("permCount", perm_count, modelPerms);
  endtask

  // One clock: drive inputs at the falling edge, advance the model, check after the rising edge.
  task automatic applyStimulus(input logic s, input logic st, input logic a);
    @(negedge clk);
    start = s;
    stall = st;
    ack   = a;
    @(posedge clk);
    modelStep(s, st, a);
    #1;
    compareAll();
  endtask

  // Runs one permutation from IDLE until done; stalls stallLen cycles in round stallAt.
  task automatic runPerm(input int stallAt, input int stallLen, input logic noise, output int latency);
    int   left = stallLen;
    logic st;
    applyStimulus(1'b1, 1'b0, 1'b0);
    latency = 0;
    for (int i = 0; i < 200; i++) begin
      st = (modelPhase == 1) && (modelIdx == stallAt) && (left > 0);
      if (st) left--;
      applyStimulus(noise ? 1'($urandom_range(0, 1)) : 1'b0, st,
                    noise ? 1'($urandom_range(0, 1)) : 1'b0);
      latency++;
      if (done) break;
    end
  endtask

  // Structural invariants on the round outputs, checked every cycle.
  always @(negedge clk) begin
    int pos;
    if (!reset) begin
      pos = 0;
      for (int k = 0; k < ROUNDS; k++) if (round[k]) pos = k;
      checkOutput("oneHotOrZero", $countones(round) <= 1, 1);
      checkOutput("roundNumMatch", round_num, pos);
      checkOutput("firstMatch", first, round[0]);
      checkOutput("lastMatch", last, round[ROUNDS-1]);
    end
  end

  initial begin
    int lat;
    start = 1'b0;
    stall = 1'b0;
    ack   = 1'b0;
    reset = 1'b1;
    modelReset();
    #1;
    checkOutput("resetReady", ready, 1);
    checkOutput("resetRound", round, 0);
    checkOutput("resetDone", done, 0);
    checkOutput("resetCount", perm_count, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Plain permutation with ack held high: done lasts one cycle.
    applyStimulus(1'b1, 1'b0, 1'b1);
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      lat++;
      if (done) break;
      checkOutput("walkNum", round_num, lat);
    end
    checkOutput("doneLatency", lat, ROUNDS);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("doneOneCycle", done, 0);
    checkOutput("countAfterFirst", perm_count, 1);

    // Three stall cycles in round 4.
    runPerm(4, 3, 1'b0, lat);
    checkOutput("stallLatency", lat, ROUNDS + 3);
    applyStimulus(1'b0, 1'b0, 1'b1);

    // Start/ack noise during RUN is ignored.
    runPerm(-1, 0, 1'b1, lat);
    checkOutput("noiseLatency", lat, ROUNDS);
    checkOutput("noiseCount", perm_count, 3);

    // Hold DONE without ack, then ack together with start.
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("doneHeld", done, 1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("ackStartReady", ready, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("noRestart", round, 0);

    // Asynchronous reset in round 12.
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("preResetNum", round_num, 12);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    modelReset();
    checkOutput("asyncReady", ready, 1);
    checkOutput("asyncRound", round, 0);
    checkOutput("asyncNum", round_num, 0);
    checkOutput("asyncFirstLast", {first, last}, 0);
    checkOutput("asyncDone", done, 0);
    checkOutput("asyncCount", perm_count, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b0, 1'b0);

    // Count wrap from 65535.
    @(negedge clk);
    start = 1'b0;
    stall = 1'b0;
    ack   = 1'b0;
    force dut.permCountReg = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.permCountReg;
    modelPerms = 65535;
    applyStimulus(1'b0, 1'b0, 1'b0);
    runPerm(-1, 0, 1'b0, lat);
    checkOutput("countWrap", perm_count, 0);
    applyStimulus(1'b0, 1'b0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 9) < 3),
                    1'($urandom_range(0, 9) < 4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
